// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver with valid/ready output and sticky overrun.
// Optional parity bit after each word when PARITY_CHECK_EN is defined.
module serial_deserializer #(
   parameter int WIDTH      = 8,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             din_valid,
   input  logic             lsb_first,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             busy,
   output logic             overrun,
   output logic             parity_err
);

`ifdef PARITY_CHECK_EN
   localparam int NBITS = WIDTH + 1;
`else
   localparam int NBITS = WIDTH;
`endif
   localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

   logic [WIDTH-1:0] r_sr;
   logic [CW-1:0]    r_cnt;
   logic             r_order;
   logic [WIDTH-1:0] r_dout;
   logic             r_dout_valid;
   logic             r_overrun;

   logic             w_order;
   logic [WIDTH-1:0] w_sr_nxt;
   logic [WIDTH-1:0] w_word;
   logic             w_shift;
   logic             w_done;
   logic             w_load;

   // the order input only matters on the first bit of a word
   assign w_order  = (r_cnt == '0) ? lsb_first : r_order;
   assign w_sr_nxt = w_order ? {din, r_sr[WIDTH-1:1]}
                             : {r_sr[WIDTH-2:0], din};
   assign w_done   = din_valid && (r_cnt == LAST);
   assign w_load   = w_done && (!r_dout_valid || dout_ready);

`ifdef PARITY_CHECK_EN
   logic r_perr;
   logic w_perr;

   // the parity bit is not shifted; data is already complete in r_sr
   assign w_shift = (r_cnt != LAST);
   assign w_word  = r_sr;
   assign w_perr  = (^{r_sr, din}) != PARITY_ODD;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perr <= 1'b0;
      end else if (w_load) begin
         r_perr <= w_perr;
      end
   end

   assign parity_err = r_perr;
`else
   assign w_shift    = 1'b1;
   assign w_word     = w_sr_nxt;
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sr         <= '0;
         r_cnt        <= '0;
         r_order      <= 1'b0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         if (din_valid) begin
            if (r_cnt == '0) begin
               r_order <= lsb_first;
            end
            if (w_shift) begin
               r_sr <= w_sr_nxt;
            end
            r_cnt <= w_done ? '0 : r_cnt + 1'b1;
         end
         if (w_load) begin
            r_dout       <= w_word;
            r_dout_valid <= 1'b1;
         end else if (w_done) begin
            r_overrun <= 1'b1;
         end else if (r_dout_valid && dout_ready) begin
            r_dout_valid <= 1'b0;
         end
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign overrun    = r_overrun;
   assign busy       = (r_cnt != '0);

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer (WIDTH=8).
// Parity cases are exercised when PARITY_CHECK_EN is defined.
module tb_serial_deserializer;

   logic       clk = 1'b0;
   logic       rst;
   logic       din;
   logic       din_valid;
   logic       lsb_first;
   logic [7:0] dout;
   logic       dout_valid;
   logic       dout_ready;
   logic       busy;
   logic       overrun;
   logic       parity_err;

   int n_chk  = 0;
   int n_fail = 0;
   logic par_flip = 1'b0;

`ifdef PARITY_CHECK_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   serial_deserializer #(.WIDTH(8), .PARITY_ODD(1'b0)) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_valid  (din_valid),
      .lsb_first  (lsb_first),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .busy       (busy),
      .overrun    (overrun),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [7:0] w, input logic lsb,
                            input int gap, input logic rdy_last);
      for (int i = 0; i < 8; i++) begin
         din       = lsb ? w[i] : w[7-i];
         lsb_first = (i == 0) ? lsb : ~lsb;
         din_valid = 1'b1;
         if (rdy_last && i == 7 && !PAR) dout_ready = 1'b1;
         tick();
         din_valid = 1'b0;
         if (i < 7) begin
            check("busy_mid", busy, 1);
            for (int g = 0; g < gap; g++) begin
               tick();
               check("busy_gap", busy, 1);
            end
         end
      end
      if (PAR) begin
         din       = (^w) ^ par_flip;
         din_valid = 1'b1;
         if (rdy_last) dout_ready = 1'b1;
         tick();
         din_valid = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1; din = 1'b0; din_valid = 1'b0;
      lsb_first = 1'b0; dout_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      check("rst_dout", dout, 8'h00);
      check("rst_valid", dout_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_ovr", overrun, 0);
      check("rst_perr", parity_err, 0);

      send_word(8'hA5, 1'b0, 0, 1'b0);
      check("a5_dout", dout, 8'hA5);
      check("a5_valid", dout_valid, 1);
      check("a5_busy", busy, 0);
      tick();
      check("a5_valid_1cyc", dout_valid, 0);
      check("a5_hold", dout, 8'hA5);

      send_word(8'h03, 1'b1, 0, 1'b0);
      check("lsb_dout", dout, 8'h03);
      send_word(8'hC0, 1'b0, 0, 1'b0);
      check("msb_dout", dout, 8'hC0);
      tick();

      send_word(8'h3C, 1'b0, 2, 1'b0);
      check("gap_dout", dout, 8'h3C);
      check("gap_valid", dout_valid, 1);
      tick();

      dout_ready = 1'b0;
      send_word(8'h81, 1'b0, 0, 1'b0);
      check("b2b_first", dout, 8'h81);
      send_word(8'h7E, 1'b0, 0, 1'b1);
      check("b2b_dout", dout, 8'h7E);
      check("b2b_valid", dout_valid, 1);
      check("b2b_ovr", overrun, 0);
      tick();
      check("b2b_cons", dout_valid, 0);

      dout_ready = 1'b0;
      send_word(8'h11, 1'b0, 0, 1'b0);
      check("ovr_w1", dout, 8'h11);
      check("ovr_pre", overrun, 0);
      send_word(8'h22, 1'b0, 0, 1'b0);
      check("ovr_keep", dout, 8'h11);
      check("ovr_valid", dout_valid, 1);
      check("ovr_flag", overrun, 1);
      dout_ready = 1'b1;
      tick();
      check("ovr_cons", dout_valid, 0);
      check("ovr_sticky", overrun, 1);
      tick();
      check("ovr_sticky2", overrun, 1);

      for (int i = 0; i < 5; i++) begin
         din = 1'b1; din_valid = 1'b1; lsb_first = 1'b0;
         tick();
      end
      din_valid = 1'b0;
      check("part_busy", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("part_rst_busy", busy, 0);
      check("part_rst_ovr", overrun, 0);
      check("part_rst_valid", dout_valid, 0);
      send_word(8'h5A, 1'b0, 0, 1'b0);
      check("after_rst_dout", dout, 8'h5A);
      check("after_rst_ovr", overrun, 0);
      tick();

      par_flip = 1'b0;
      send_word(8'hA5, 1'b0, 0, 1'b0);
      check("par_ok", parity_err, 0);
      tick();
      par_flip = 1'b1;
      send_word(8'hA5, 1'b0, 0, 1'b0);
      check("par_dout", dout, 8'hA5);
      check("par_bad", parity_err, PAR ? 1 : 0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_deserializer.md
Name: serial_deserializer

Overview:
- Receive end of the serial bit path driven by the team's MUX/D-flip-flop shift element.
- Collects one bit per accepted clock into a WIDTH-bit shift register.
- Presents each completed word on a registered parallel output with a valid/ready handshake.
- Bit order is selectable per word: MSB-first or LSB-first.

Parameters:
- WIDTH, 8: data word width in bits; legal range 2..32.
- PARITY_ODD, 0: parity sense when the optional parity check is built in. 0 = even, 1 = odd.

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- rst  input  1  synchronous, active-high reset
- din  input  1  serial data bit
- din_valid  input  1  din is accepted on a rising edge where din_valid=1
- lsb_first  input  1  bit order for the current word; sampled only on the first bit of a word
- dout  output  WIDTH  assembled parallel word
- dout_valid  output  1  dout holds an unconsumed word
- dout_ready  input  1  consumer accepts dout on a rising edge where dout_valid=1 and dout_ready=1
- busy  output  1  high while a word is partially received (bit count nonzero)
- overrun  output  1  sticky flag: a completed word was dropped
- parity_err  output  1  parity result for the word on dout (see Optional Feature)

Behaviour:
- Reset (rst=1 at a rising edge): shift register=0, bit count=0, latched order=0, dout=0, dout_valid=0, busy=0, overrun=0, parity_err=0.
  - Reset dominates all other inputs that cycle.
  - A partially received word is discarded.
- The bit counter runs 0..WIDTH-1; this is the count of data bits already accepted in the current word.
- On an accepted bit at count 0, latch lsb_first into the order register and use it for the whole word. Changes to lsb_first mid-word are ignored.
- Shift rules on each accepted bit:
  - MSB-first: sr <= {sr[WIDTH-2:0], din}.
  - LSB-first: sr <= {din, sr[WIDTH-1:1]}.
- Bit accepted at count WIDTH-1 completes the word; count wraps to 0 on the same edge.
- Completion with output slot free, or being consumed on the same edge (dout_valid & dout_ready):
  - dout <= fully shifted word; dout_valid <= 1 on that same edge.
  - Latency: the last bit's edge → dout_valid is seen high immediately after it.
  - Back-to-back words with no idle cycles are supported.
- Completion while dout_valid=1 and dout_ready=0:
  - The new word is dropped; dout and dout_valid are unchanged.
  - overrun <= 1. overrun clears only on rst.
- Consume without completion: dout_valid <= 0. dout keeps its last value.
- din_valid=0 holds the shift register and count unchanged, with no timeout.
- busy = (bit count != 0), taken combinationally from registered state.
- Internal states:
  - IDLE: count 0, no word pending.
  - SHIFT: count nonzero.
  - HOLD: dout_valid=1.
  - SHIFT and HOLD may coexist. Implement as counter plus valid flag, not a one-hot FSM.

Optional Feature:
- Macro: PARITY_CHECK_EN
- Defined:
  - After the WIDTH data bits, one extra parity bit is accepted; the counter range becomes 0..WIDTH.
  - Completion (load/overrun decision) happens on the parity-bit edge.
  - parity_err loads with the word and is valid while dout_valid=1:
    - PARITY_ODD=0: ^{data,parity} != 0.
    - PARITY_ODD=1: ^{data,parity} != 1.
  - A dropped word does not update parity_err.
- Not defined: no parity bit, counter range 0..WIDTH-1, parity_err tied to 0.

Test Plan:
- WIDTH=8, MSB-first, bits 1,0,1,0,0,1,0,1 on consecutive cycles, dout_ready=1 → dout=8'hA5, dout_valid high for exactly 1 cycle, busy high during bits 2..8.
- Same bit sequence with lsb_first=1 latched at bit 1, then lsb_first toggled mid-word → dout=8'hA5 bit-reversed = 8'hA5 reversed = 8'hA5? Use bits 1,1,0,0,0,0,0,0 instead → dout=8'h03 (LSB-first) versus 8'hC0 (MSB-first).
- din_valid gapped with random idle cycles across word 8'h3C → dout=8'h3C, count held during gaps.
- dout_ready=0, two full words sent (8'h11 then 8'h22) → dout stays 8'h11, overrun=1; raise dout_ready → dout_valid falls, overrun stays 1 until rst.
- rst asserted after 5 of 8 bits → busy=0, count=0; next full word 8'h5A received correctly, overrun=0.
- With PARITY_CHECK_EN defined and PARITY_ODD=0:
  - Word 8'hA5 plus parity 0 → parity_err=0.
  - Word 8'hA5 plus parity 1 → parity_err=1.
  - Without the macro, parity_err is always 0.
